// File: rtl/tile_pkg.sv
// Shared widths, CPU write-select codes and FSM state codes for the
// scanline tile fetch sequencer.
package tile_pkg;

    localparam int MAP_AW = 13;
    localparam int ROM_AW = 11;
    localparam int LB_AW  = 7;

    typedef enum logic [1:0] {
        SEL_MAP  = 2'd0,
        SEL_PAL  = 2'd1,
        SEL_ROM  = 2'd2,
        SEL_NONE = 2'd3
    } cpu_sel_e;

    typedef logic [1:0] fsm_t;

    localparam fsm_t ST_IDLE  = 2'd0;
    localparam fsm_t ST_FETCH = 2'd1;
    localparam fsm_t ST_DRAIN = 2'd2;

endpackage

// File: rtl/tile_fetch_ctrl_addr_gen.sv
// Combinational address composition: tile row / pixel row from the line,
// scrolled tile column, tilemap address and tile ROM row address.
module tile_addr_gen
    import tile_pkg::*;
#(
    parameter int MAP_W_LOG2 = 7
) (
    input  logic [8:0]        i_line,
    input  logic [8:0]        i_scroll_y,
    input  logic [LB_AW-1:0]  i_col,
    input  logic [LB_AW-1:0]  i_scroll_x,
    input  logic [7:0]        i_tile_idx,
    output logic [MAP_AW-1:0] o_map_addr,
    output logic [ROM_AW-1:0] o_rom_addr
);

    localparam int RW = MAP_AW - MAP_W_LOG2;

    logic [8:0]            y;
    logic [RW-1:0]         trow;
    logic [MAP_W_LOG2-1:0] cc;
    logic [2:0]            prow;

    // Both the row and the column wrap around the tilemap edges.
    always_comb begin
        y          = i_line + i_scroll_y;
        trow       = RW'(y[8:3]);
        prow       = y[2:0];
        cc         = MAP_W_LOG2'({1'b0, i_col} + {1'b0, i_scroll_x});
        o_map_addr = {trow, cc};
        o_rom_addr = {i_tile_idx, prow};
    end

endmodule

// File: rtl/tile_fetch_ctrl.sv
// Scanline tile fetch sequencer and RAM write-port arbiter.
// Optional SCROLL_EN adds latched tile-column / pixel-line scroll inputs.
module tile_fetch_ctrl
    import tile_pkg::*;
#(
    parameter int COLS       = 80,
    parameter int MAP_W_LOG2 = 7
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [8:0]        i_line,
`ifdef SCROLL_EN
    input  logic [6:0]        i_scroll_x,
    input  logic [8:0]        i_scroll_y,
`endif
    output logic              o_busy,
    output logic              o_done,
    output logic              o_map_ren,
    output logic [MAP_AW-1:0] o_map_raddr,
    input  logic [7:0]        i_map_rdata,
    output logic              o_pal_ren,
    output logic [MAP_AW-1:0] o_pal_raddr,
    input  logic [1:0]        i_pal_rdata,
    output logic              o_rom_ren,
    output logic [ROM_AW-1:0] o_rom_raddr,
    input  logic [7:0]        i_rom_rdata,
    output logic              o_lb_wen,
    output logic [LB_AW-1:0]  o_lb_waddr,
    output logic [9:0]        o_lb_wdata,
    input  logic              i_cpu_req,
    input  logic [1:0]        i_cpu_sel,
    input  logic [MAP_AW-1:0] i_cpu_addr,
    input  logic [7:0]        i_cpu_wdata,
    output logic              o_cpu_ack,
    output logic [MAP_AW-1:0] o_waddr,
    output logic [7:0]        o_wdata,
    output logic              o_map_wen,
    output logic              o_pal_wen,
    output logic              o_rom_wen
);

    localparam logic [LB_AW-1:0] LAST_COL = LB_AW'(COLS - 1);

    logic [6:0] sx_in;
    logic [8:0] sy_in;

`ifdef SCROLL_EN
    assign sx_in = i_scroll_x;
    assign sy_in = i_scroll_y;
`else
    assign sx_in = '0;
    assign sy_in = '0;
`endif

    fsm_t             state_q, state_d;
    logic [LB_AW-1:0] col_q, col_d;
    logic [8:0]       line_q, line_d;
    logic [6:0]       sx_q, sx_d;
    logic [8:0]       sy_q, sy_d;

    logic             s1_v_q, s1_v_d;
    logic             s1_last_q, s1_last_d;
    logic [LB_AW-1:0] s1_col_q, s1_col_d;
    logic             s2_v_q, s2_v_d;
    logic             s2_last_q, s2_last_d;
    logic [LB_AW-1:0] s2_col_q, s2_col_d;
    logic [1:0]       s2_pal_q, s2_pal_d;
    logic             s3_v_q, s3_v_d;
    logic             s3_last_q, s3_last_d;
    logic [LB_AW-1:0] s3_col_q, s3_col_d;
    logic [1:0]       s3_pal_q, s3_pal_d;
    logic [7:0]       s3_bits_q, s3_bits_d;

    logic              ack_q, ack_d;
    logic              map_wen_q, map_wen_d;
    logic              pal_wen_q, pal_wen_d;
    logic              rom_wen_q, rom_wen_d;
    logic [MAP_AW-1:0] waddr_q, waddr_d;
    logic [7:0]        wdata_q, wdata_d;

    logic              issue;
    logic              last_issue;
    logic              grant;
    logic [MAP_AW-1:0] map_addr;
    logic [ROM_AW-1:0] rom_addr;

    tile_addr_gen #(
        .MAP_W_LOG2 (MAP_W_LOG2)
    ) u_addr_gen (
        .i_line     (line_q),
        .i_scroll_y (sy_q),
        .i_col      (col_q),
        .i_scroll_x (sx_q),
        .i_tile_idx (i_map_rdata),
        .o_map_addr (map_addr),
        .o_rom_addr (rom_addr)
    );

    assign issue      = (state_q == ST_FETCH);
    assign last_issue = issue && (col_q == LAST_COL);

    // Writes are only granted from an idle cycle with no competing start,
    // and never in the ack cycle, so they cannot collide with fetch reads.
    assign grant = (state_q == ST_IDLE) && i_cpu_req && !i_start && !ack_q;

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        line_d  = line_q;
        sx_d    = sx_q;
        sy_d    = sy_q;
        unique case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_FETCH;
                    col_d   = '0;
                    line_d  = i_line;
                    sx_d    = sx_in;
                    sy_d    = sy_in;
                end
            end
            ST_FETCH: begin
                col_d = col_q + 1'b1;
                if (last_issue) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (s3_v_q && s3_last_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        s1_v_d    = issue;
        s1_last_d = last_issue;
        s1_col_d  = issue ? col_q : s1_col_q;
        s2_v_d    = s1_v_q;
        s2_last_d = s1_last_q;
        s2_col_d  = s1_v_q ? s1_col_q : s2_col_q;
        s2_pal_d  = s1_v_q ? i_pal_rdata : s2_pal_q;
        s3_v_d    = s2_v_q;
        s3_last_d = s2_last_q;
        s3_col_d  = s2_v_q ? s2_col_q : s3_col_q;
        s3_pal_d  = s2_v_q ? s2_pal_q : s3_pal_q;
        s3_bits_d = s2_v_q ? i_rom_rdata : s3_bits_q;
    end

    always_comb begin
        ack_d     = grant;
        map_wen_d = 1'b0;
        pal_wen_d = 1'b0;
        rom_wen_d = 1'b0;
        waddr_d   = grant ? i_cpu_addr : '0;
        wdata_d   = grant ? i_cpu_wdata : '0;
        if (grant) begin
            unique case (cpu_sel_e'(i_cpu_sel))
                SEL_MAP:  map_wen_d = 1'b1;
                SEL_PAL:  pal_wen_d = 1'b1;
                SEL_ROM:  rom_wen_d = 1'b1;
                SEL_NONE: map_wen_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            col_q     <= '0;
            line_q    <= '0;
            sx_q      <= '0;
            sy_q      <= '0;
            s1_v_q    <= 1'b0;
            s1_last_q <= 1'b0;
            s1_col_q  <= '0;
            s2_v_q    <= 1'b0;
            s2_last_q <= 1'b0;
            s2_col_q  <= '0;
            s2_pal_q  <= '0;
            s3_v_q    <= 1'b0;
            s3_last_q <= 1'b0;
            s3_col_q  <= '0;
            s3_pal_q  <= '0;
            s3_bits_q <= '0;
            ack_q     <= 1'b0;
            map_wen_q <= 1'b0;
            pal_wen_q <= 1'b0;
            rom_wen_q <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            line_q    <= line_d;
            sx_q      <= sx_d;
            sy_q      <= sy_d;
            s1_v_q    <= s1_v_d;
            s1_last_q <= s1_last_d;
            s1_col_q  <= s1_col_d;
            s2_v_q    <= s2_v_d;
            s2_last_q <= s2_last_d;
            s2_col_q  <= s2_col_d;
            s2_pal_q  <= s2_pal_d;
            s3_v_q    <= s3_v_d;
            s3_last_q <= s3_last_d;
            s3_col_q  <= s3_col_d;
            s3_pal_q  <= s3_pal_d;
            s3_bits_q <= s3_bits_d;
            ack_q     <= ack_d;
            map_wen_q <= map_wen_d;
            pal_wen_q <= pal_wen_d;
            rom_wen_q <= rom_wen_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
        end
    end

    assign o_busy      = (state_q != ST_IDLE);
    assign o_done      = s3_v_q && s3_last_q;
    assign o_map_ren   = issue;
    assign o_map_raddr = issue ? map_addr : '0;
    assign o_pal_ren   = issue;
    assign o_pal_raddr = issue ? map_addr : '0;
    assign o_rom_ren   = s1_v_q;
    assign o_rom_raddr = s1_v_q ? rom_addr : '0;
    assign o_lb_wen    = s3_v_q;
    assign o_lb_waddr  = s3_v_q ? s3_col_q : '0;
    assign o_lb_wdata  = s3_v_q ? {s3_pal_q, s3_bits_q} : '0;
    assign o_cpu_ack   = ack_q;
    assign o_waddr     = waddr_q;
    assign o_wdata     = wdata_q;
    assign o_map_wen   = map_wen_q;
    assign o_pal_wen   = pal_wen_q;
    assign o_rom_wen   = rom_wen_q;

endmodule
